// File: rtl/dcm_phaseshift_multi.sv
// Multi-channel DCM variable phase-shift sequencer: walks one DCM at a time toward a signed target.
// Optional PSDONE watchdog is built when PSHIFT_TIMEOUT_EN is defined.
module dcm_phaseshift_multi #(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 2,
    parameter int CHW      = 3,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [CHW-1:0]      chan_i,
    input  logic [WIDTH-1:0]    value_i,
    input  logic                load_i,
    input  logic                zero_i,
    output logic [WIDTH-1:0]    value_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                ovf_o,
    output logic                tmo_o,
    output logic [CHANNELS-1:0] dcm_psen_o,
    output logic                dcm_psincdec_o,
    input  logic [CHANNELS-1:0] dcm_psdone_i,
    input  logic [CHANNELS-1:0] dcm_ovf_i
);
    typedef enum logic [2:0] {IDLE, CHECK, STEP, WAIT, DONE} state_t;

    localparam logic signed [WIDTH-1:0] MAXV = WIDTH'((1 << (WIDTH - 1)) - 1);

    state_t                  state, state_nx;
    logic [CHW-1:0]          ch;
    logic signed [WIDTH-1:0] target, cur, value_sat;
    logic [WIDTH-1:0]        tracked [CHANNELS];
    logic [CHANNELS-1:0]     ch_mask;
    logic                    chan_ok, accept, zero_hit;
    logic                    psdone_sel, ovf_sel, step_upd, tmo_hit;

    assign chan_ok   = int'(chan_i) < CHANNELS;
    assign accept    = (state == IDLE) && load_i && !zero_i && chan_ok;
    assign zero_hit  = (state == IDLE) && zero_i && chan_ok;
    // Only the most negative code lies outside the symmetric legal range.
    assign value_sat = ($signed(value_i) < -MAXV) ? -MAXV : $signed(value_i);

    always_comb begin
        ch_mask = '0;
        cur     = '0;
        value_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch_mask[c] = (ch == CHW'(c));
            if (ch_mask[c])
                cur = tracked[c];
            if (chan_i == CHW'(c))
                value_o = tracked[c];
        end
    end

    assign psdone_sel = |(dcm_psdone_i & ch_mask);
    assign ovf_sel    = |(dcm_ovf_i & ch_mask);
    assign step_upd   = (state == WAIT) && psdone_sel && !ovf_sel;

`ifdef PSHIFT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            tcnt <= '0;
        else if (state != WAIT)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    assign tmo_hit = (state == WAIT) && !psdone_sel && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            tmo_o <= 1'b0;
        else if (accept)
            tmo_o <= 1'b0;
        else if (tmo_hit)
            tmo_o <= 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CHECK;
            CHECK:   state_nx = (cur == target) ? DONE : STEP;
            STEP:    state_nx = WAIT;
            WAIT: begin
                if (psdone_sel)
                    state_nx = ovf_sel ? DONE : CHECK;
                else if (tmo_hit)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // PSEN is a pure decode of the state register so reset kills it without a clock.
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);
    assign dcm_psen_o = (state == STEP) ? ch_mask : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ch             <= '0;
            target         <= '0;
            dcm_psincdec_o <= 1'b0;
            ovf_o          <= 1'b0;
        end else begin
            if (accept) begin
                ch     <= chan_i;
                target <= value_sat;
                ovf_o  <= 1'b0;
            end
            if (state == CHECK)
                dcm_psincdec_o <= (target > cur);
            if ((state == WAIT) && psdone_sel && ovf_sel)
                ovf_o <= 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i)
                tracked[c] <= '0;
            else if (zero_hit && (chan_i == CHW'(c)))
                tracked[c] <= '0;
            else if (step_upd && ch_mask[c])
                tracked[c] <= dcm_psincdec_o ? tracked[c] + WIDTH'(1) : tracked[c] - WIDTH'(1);
        end
    end

endmodule

// File: doc/dcm_phaseshift_multi.md
# dcm_phaseshift_multi

Multi-channel variable phase-shift sequencer for DCM_SP-class clock managers in the ADC clock path. It drives a signed target phase into any of `CHANNELS` DCMs one PSEN step at a time and tracks each DCM's actual phase. It detects DCM phase-shift overflow and, optionally, a missing PSDONE. It sits between the register interface and the DCMs in the clock-management block, on the phase-shift clock domain.

## Interface
Parameters:
- `WIDTH`, 9: signed phase value width in bits; legal targets are -(2^(WIDTH-1)-1) .. +(2^(WIDTH-1)-1).
- `CHANNELS`, 2: number of DCMs controlled (1..8).
- `CHW`, 3: channel-select width; must satisfy 2^CHW >= CHANNELS.
- `TIMEOUT`, 1023: maximum clk_i cycles to wait for PSDONE (only with the timeout feature).

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` in 1: phase-shift clock; must also drive the DCM PSCLK.
- `reset_i` in 1: asynchronous active-high reset.
- `chan_i` in CHW: channel addressed by load/zero/readback.
- `value_i` in WIDTH: signed target phase.
- `load_i` in 1: start a move of `chan_i` to `value_i`.
- `zero_i` in 1: clear the tracked phase of `chan_i` to 0. Asserted together with that DCM's RST.
- `value_o` out WIDTH: tracked phase of `chan_i`; combinational mux of the registered per-channel values.
- `busy_o` out 1: a move is in progress.
- `done_o` out 1: one-cycle pulse when a move ends, whether successful or not.
- `ovf_o` out 1: sticky; a move stopped at the DCM shift limit.
- `tmo_o` out 1: sticky; PSDONE timeout.
- `dcm_psen_o` out CHANNELS: per-channel PSEN.
- `dcm_psincdec_o` out 1: shared PSINCDEC; 1 = increment.
- `dcm_psdone_i` in CHANNELS: per-channel PSDONE.
- `dcm_ovf_i` in CHANNELS: per-channel STATUS[0] (phase-shift overflow).

## Operation
- FSM states: IDLE, CHECK, STEP, WAIT, DONE.
- **IDLE**:
  - `load_i` with `chan_i` < CHANNELS latches the channel and target, then goes to CHECK.
  - `load_i` with `chan_i` >= CHANNELS is ignored.
  - `load_i` in any other state is ignored; there is no queueing.
- **CHECK**:
  - tracked == target: go to DONE.
  - otherwise: go to STEP, with `dcm_psincdec_o` = (target > tracked), using a signed compare.
- **STEP**: `dcm_psen_o[ch]` high for exactly one cycle, then WAIT.
- **WAIT**: on `dcm_psdone_i[ch]`:
  - If `dcm_ovf_i[ch]` is high in the same cycle: the tracked value is unchanged, `ovf_o` is set, go to DONE.
  - Otherwise: tracked += 1 or -= 1, go to CHECK.
- **DONE**: `done_o` = 1 for one cycle, then IDLE.
- `busy_o` = 1 in every state except IDLE.
- `dcm_psincdec_o` is held stable from STEP through WAIT.
- PSDONE on a non-selected channel, or outside WAIT, is ignored.
- `zero_i` is acted on only in IDLE; it has priority over a `load_i` in the same cycle, and that load is dropped.
- Sticky flags `ovf_o` and `tmo_o` clear on the next accepted `load_i`.
- Arithmetic is WIDTH-bit signed. Targets outside the legal range are saturated to ±(2^(WIDTH-1)-1) at latch time.

## Timing
- Reset values: state IDLE; all tracked values 0; `busy_o`, `done_o`, `ovf_o`, `tmo_o`, `dcm_psen_o`, `dcm_psincdec_o` all 0.
- `reset_i` mid-move returns to IDLE immediately. `dcm_psen_o` drops asynchronously, with no partial pulse afterwards.
- Load accepted at edge T:
  - `busy_o` is high from T+1.
  - With target == tracked, `done_o` is high in cycle T+2.
- Each step costs 2 + D cycles, where D is the number of cycles from the PSEN cycle to PSDONE (D >= 1).
- Therefore an N-step move with constant D has `done_o` at T+2+N·(2+D).
- `value_o` updates in the cycle after the PSDONE edge.

## Configuration
- `PSHIFT_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If PSDONE is absent for `TIMEOUT` cycles: set `tmo_o`, leave the tracked value unchanged, go to DONE.
- `PSHIFT_TIMEOUT_EN` undefined:
  - No counter is built.
  - WAIT persists until PSDONE or reset.
  - `tmo_o` is tied to 0.

## Test plan
- Reset, then load ch0 to +5 with PSDONE returned 3 cycles after each PSEN:
  - exactly 5 PSEN pulses with incdec = 1;
  - `value_o` = 5;
  - `done_o` at T+27.
- Ch1 at +3, load ch1 to -2:
  - 5 decrement pulses, only on `dcm_psen_o[1]`;
  - `value_o`(ch1) = -2;
  - ch0 unchanged.
- Load ch0 to +100, raise `dcm_ovf_i[0]` with the PSDONE of step 40:
  - stop at `value_o` = 39, `ovf_o` = 1, `done_o` pulse;
  - the next load clears `ovf_o`.
- With `PSHIFT_TIMEOUT_EN` and TIMEOUT = 16, withhold PSDONE:
  - `tmo_o` = 1 and `done_o` 16 cycles into WAIT;
  - value unchanged.
  - Without the macro, FSM remains in WAIT with `busy_o` = 1.
- Mid-move, assert `reset_i` asynchronously:
  - all outputs 0 without waiting for a clock;
  - values 0.
- Then issue `load_i` during busy, `load_i` with `chan_i` = CHANNELS, and `zero_i` + `load_i` together:
  - first two ignored;
  - third zeroes the channel with no PSEN.
